// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read sequencer: sweep table, register file
// slot indices and the sequencer state encoding.
package rtc_pkg;

  localparam int unsigned N_REGS = 9;

  localparam logic [3:0] MEM_SEC      = 4'd0;
  localparam logic [3:0] MEM_MIN      = 4'd1;
  localparam logic [3:0] MEM_HOUR     = 4'd2;
  localparam logic [3:0] MEM_DAY      = 4'd3;
  localparam logic [3:0] MEM_MONTH    = 4'd4;
  localparam logic [3:0] MEM_YEAR     = 4'd5;
  localparam logic [3:0] MEM_TMR_HOUR = 4'd7;
  localparam logic [3:0] MEM_TMR_MIN  = 4'd8;
  localparam logic [3:0] MEM_TMR_SEC  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP_A,
    ST_DATA,
    ST_GAP_D,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [7:0] rtc_addr(input logic [3:0] k);
    case (k)
      4'd0:    rtc_addr = 8'h21;
      4'd1:    rtc_addr = 8'h22;
      4'd2:    rtc_addr = 8'h23;
      4'd3:    rtc_addr = 8'h24;
      4'd4:    rtc_addr = 8'h25;
      4'd5:    rtc_addr = 8'h26;
      4'd6:    rtc_addr = 8'h43;
      4'd7:    rtc_addr = 8'h42;
      4'd8:    rtc_addr = 8'h41;
      default: rtc_addr = 8'h21;
    endcase
  endfunction

  // Slot 6 and 10..15 are never produced; 11 belongs to the register file.
  function automatic logic [3:0] mem_index(input logic [3:0] k);
    case (k)
      4'd0:    mem_index = MEM_SEC;
      4'd1:    mem_index = MEM_MIN;
      4'd2:    mem_index = MEM_HOUR;
      4'd3:    mem_index = MEM_DAY;
      4'd4:    mem_index = MEM_MONTH;
      4'd5:    mem_index = MEM_YEAR;
      4'd6:    mem_index = MEM_TMR_HOUR;
      4'd7:    mem_index = MEM_TMR_MIN;
      4'd8:    mem_index = MEM_TMR_SEC;
      default: mem_index = MEM_SEC;
    endcase
  endfunction

endpackage

// File: rtl/rtc_read_sequencer_if.sv
// Multiplexed address/data bus between the FPGA and the external RTC chip.
interface rtc_read_sequencer_if;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d_n;

  modport master (input ad_in, output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d_n);
  modport slave  (output ad_in, input ad_out, ad_oe, cs_n, rd_n, wr_n, a_d_n);
endinterface

// File: rtl/rtc_bus_cycle.sv
// One RTC register read: address latch, turnaround, read strobe, turnaround,
// each phase CLK_PER_PHASE cycles long. Bus pins are registered from the state.
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_PER_PHASE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [7:0]            addr,
  output logic [7:0]            rd_byte,
  output logic                  done,
  rtc_read_sequencer_if.master  bus
);

  localparam logic [7:0] PHASE_LAST = 8'(CLK_PER_PHASE - 1);

  state_t     state, state_next;
  logic [7:0] phase;
  logic       last;
  logic       cap_pend;

  assign last = (phase == PHASE_LAST);

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (go)   state_next = ST_ADDR;
      ST_ADDR:  if (last) state_next = ST_GAP_A;
      ST_GAP_A: if (last) state_next = ST_DATA;
      ST_DATA:  if (last) state_next = ST_GAP_D;
      ST_GAP_D: if (last) begin
        state_next = ST_IDLE;
        done       = 1'b1;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Pins lag the state by one cycle, so the byte is taken one edge after the
  // last DATA state cycle, i.e. at the end of the final rd_n-low cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      cap_pend   <= 1'b0;
      rd_byte    <= '0;
      bus.ad_out <= '0;
      bus.ad_oe  <= 1'b0;
      bus.cs_n   <= 1'b1;
      bus.rd_n   <= 1'b1;
      bus.wr_n   <= 1'b1;
      bus.a_d_n  <= 1'b1;
    end else begin
      state    <= state_next;
      phase    <= (state == ST_IDLE || state_next != state) ? '0 : phase + 8'd1;
      cap_pend <= (state == ST_DATA) && last;
      if (cap_pend) rd_byte <= bus.ad_in;

      bus.ad_out <= '0;
      bus.ad_oe  <= 1'b0;
      bus.cs_n   <= 1'b1;
      bus.rd_n   <= 1'b1;
      bus.wr_n   <= 1'b1;
      bus.a_d_n  <= 1'b1;
      case (state)
        ST_ADDR: begin
          bus.cs_n   <= 1'b0;
          bus.a_d_n  <= 1'b0;
          bus.wr_n   <= 1'b0;
          bus.ad_oe  <= 1'b1;
          bus.ad_out <= addr;
        end
        ST_DATA: begin
          bus.cs_n <= 1'b0;
          bus.rd_n <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rtc_read_sequencer.sv
// Sweeps the nine RTC time/timer registers into the register file, on request
// or from the idle poll timer.
module rtc_read_sequencer
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_PER_PHASE = 4,
  parameter int unsigned POLL_INTERVAL = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  rtc_read_sequencer_if.master  rtc,
  output logic [3:0]            mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  sweep_done
);

  localparam logic [31:0] POLL_LAST = 32'(POLL_INTERVAL - 1);
  localparam logic [3:0]  IDX_LAST  = 4'(N_REGS - 1);

  state_t      state, state_next;
  logic [3:0]  idx;
  logic [31:0] poll_cnt;
  logic        poll_hit;
  logic        last_reg;
  logic        go;
  logic        cyc_done;
  logic [7:0]  rd_byte;
  logic [7:0]  cur_addr;

  assign poll_hit = (POLL_INTERVAL != 0) && (poll_cnt >= POLL_LAST);
  assign last_reg = (idx == IDX_LAST);
  assign cur_addr = rtc_addr(idx);

  rtc_bus_cycle #(.CLK_PER_PHASE(CLK_PER_PHASE)) u_bus (
    .clk     (clk),
    .reset   (reset),
    .go      (go),
    .addr    (cur_addr),
    .rd_byte (rd_byte),
    .done    (cyc_done),
    .bus     (rtc)
  );

  // ST_ADDR here covers the whole bus cycle run by u_bus.
  always_comb begin
    state_next = state;
    go         = 1'b0;
    case (state)
      ST_IDLE: if (start || poll_hit) begin
        state_next = ST_ADDR;
        go         = 1'b1;
      end
      ST_ADDR:  if (cyc_done) state_next = ST_WRITE;
      ST_WRITE: if (last_reg) state_next = ST_DONE;
                else begin
                  state_next = ST_ADDR;
                  go         = 1'b1;
                end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Poll counter restarts as DONE is entered and runs through DONE and IDLE,
  // so the next auto-sweep begins POLL_INTERVAL cycles after sweep_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      poll_cnt   <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_WRITE && !last_reg) idx <= idx + 4'd1;
      else if (state == ST_DONE)          idx <= '0;

      if (state == ST_WRITE && last_reg)
        poll_cnt <= '0;
      else if ((state == ST_IDLE || state == ST_DONE) && poll_cnt != '1)
        poll_cnt <= poll_cnt + 32'd1;

      mem_we     <= (state == ST_WRITE);
      busy       <= (state == ST_ADDR) || (state == ST_WRITE);
      sweep_done <= (state == ST_DONE);
      if (state == ST_WRITE) begin
        mem_addr <= mem_index(idx);
        mem_data <= rd_byte;
      end
    end
  end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed bench: three sequencers (P=4 manual, P=4 with 50-cycle poll, P=1 no poll)
// against a simple RTC bus model answering 12h..20h.
module tb_rtc_read_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1, start2;

  logic [3:0] mem_addr0, mem_addr1, mem_addr2;
  logic [7:0] mem_data0, mem_data1, mem_data2;
  logic       mem_we0, mem_we1, mem_we2;
  logic       busy0, busy1, busy2;
  logic       sweep_done0, sweep_done1, sweep_done2;

  logic [7:0] lat0, lat1, lat2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [3:0] exp_addr [9];
  logic [7:0] exp_data [9];

  rtc_read_sequencer_if bus0 ();
  rtc_read_sequencer_if bus1 ();
  rtc_read_sequencer_if bus2 ();

  rtc_read_sequencer #(.CLK_PER_PHASE(4), .POLL_INTERVAL(100000)) u0 (
    .clk(clk), .reset(reset), .start(start0), .rtc(bus0),
    .mem_addr(mem_addr0), .mem_data(mem_data0), .mem_we(mem_we0),
    .busy(busy0), .sweep_done(sweep_done0)
  );

  rtc_read_sequencer #(.CLK_PER_PHASE(4), .POLL_INTERVAL(50)) u1 (
    .clk(clk), .reset(reset), .start(start1), .rtc(bus1),
    .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_we(mem_we1),
    .busy(busy1), .sweep_done(sweep_done1)
  );

  rtc_read_sequencer #(.CLK_PER_PHASE(1), .POLL_INTERVAL(0)) u2 (
    .clk(clk), .reset(reset), .start(start2), .rtc(bus2),
    .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_we(mem_we2),
    .busy(busy2), .sweep_done(sweep_done2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] resp(input logic [7:0] a);
    case (a)
      8'h21:   resp = 8'h12;
      8'h22:   resp = 8'h13;
      8'h23:   resp = 8'h14;
      8'h24:   resp = 8'h15;
      8'h25:   resp = 8'h16;
      8'h26:   resp = 8'h17;
      8'h43:   resp = 8'h18;
      8'h42:   resp = 8'h19;
      8'h41:   resp = 8'h20;
      default: resp = 8'hEE;
    endcase
  endfunction

  // RTC model: latch the address on an address-write cycle, answer while rd_n is low.
  always @(negedge clk) begin
    if (!bus0.wr_n && !bus0.a_d_n) lat0 <= bus0.ad_out;
    if (!bus1.wr_n && !bus1.a_d_n) lat1 <= bus1.ad_out;
    if (!bus2.wr_n && !bus2.a_d_n) lat2 <= bus2.ad_out;
  end

  always_comb bus0.ad_in = bus0.rd_n ? 8'hFF : resp(lat0);
  always_comb bus1.ad_in = bus1.rd_n ? 8'hFF : resp(lat1);
  always_comb bus2.ad_in = bus2.rd_n ? 8'hFF : resp(lat2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic we_exp;
    int   k;
    int   nwe;

    exp_addr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9};
    exp_data = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h20};

    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (3) step();

    chk("rst_cs_n",   bus0.cs_n, 1);
    chk("rst_rd_n",   bus0.rd_n, 1);
    chk("rst_wr_n",   bus0.wr_n, 1);
    chk("rst_a_d_n",  bus0.a_d_n, 1);
    chk("rst_ad_oe",  bus0.ad_oe, 0);
    chk("rst_ad_out", bus0.ad_out, 0);
    chk("rst_we",     mem_we0, 0);
    chk("rst_addr",   mem_addr0, 0);
    chk("rst_data",   mem_data0, 0);
    chk("rst_busy",   busy0, 0);
    chk("rst_done",   sweep_done0, 0);

    reset = 1'b0;
    step();
    step();

    start0 = 1'b1;
    start1 = 1'b1;
    start2 = 1'b1;
    step();
    cyc    = 0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    chk("u0_busy0", busy0, 0);

    for (int i = 1; i <= 210; i++) begin
      step();

      we_exp = (cyc % 17 == 0) && (cyc >= 17) && (cyc <= 153);
      chk("u0_we", mem_we0, we_exp);
      if (we_exp) begin
        k = cyc / 17 - 1;
        chk("u0_addr", mem_addr0, exp_addr[k]);
        chk("u0_data", mem_data0, exp_data[k]);
      end
      chk("u0_done", sweep_done0, cyc == 154);
      chk("u0_busy", busy0, (cyc >= 1) && (cyc <= 153));
      if (cyc <= 4) begin
        chk("addr_ad_out", bus0.ad_out, 8'h21);
        chk("addr_a_d_n",  bus0.a_d_n, 0);
        chk("addr_wr_n",   bus0.wr_n, 0);
        chk("addr_cs_n",   bus0.cs_n, 0);
        chk("addr_ad_oe",  bus0.ad_oe, 1);
      end
      if (cyc == 5) begin
        chk("gap_wr_n",  bus0.wr_n, 1);
        chk("gap_ad_oe", bus0.ad_oe, 0);
      end
      chk("oe_rd_excl", {bus0.ad_oe & ~bus0.rd_n, bus1.ad_oe & ~bus1.rd_n,
                         bus2.ad_oe & ~bus2.rd_n}, 0);

      chk("u1_busy", busy1, ((cyc >= 1) && (cyc <= 153)) || (cyc >= 204));
      chk("u1_done", sweep_done1, cyc == 154);

      we_exp = (cyc % 5 == 0) && (cyc >= 5) && (cyc <= 45);
      chk("u2_we", mem_we2, we_exp);
      if (we_exp) begin
        k = cyc / 5 - 1;
        chk("u2_addr", mem_addr2, exp_addr[k]);
        chk("u2_data", mem_data2, exp_data[k]);
      end
      chk("u2_done", sweep_done2, cyc == 46);
      chk("u2_busy", busy2, (cyc >= 1) && (cyc <= 45));
    end

    start0 = 1'b1;
    step();
    cyc = 0;
    nwe = 0;
    for (int i = 1; i <= 172; i++) begin
      step();
      if (mem_we0) nwe++;
      if (cyc == 154) chk("held_writes", nwe, 9);
      if (cyc == 155) chk("held_busy_lo", busy0, 0);
      if (cyc == 156) chk("held_busy_hi", busy0, 1);
      if (cyc == 172) begin
        chk("held_we2",   mem_we0, 1);
        chk("held_addr2", mem_addr0, 0);
        chk("held_data2", mem_data0, 8'h12);
      end
    end
    start0 = 1'b0;

    while (cyc < 199) step();
    chk("mid_rd_n", bus0.rd_n, 0);
    chk("mid_cs_n", bus0.cs_n, 0);
    reset = 1'b1;
    step();
    chk("abort_cs_n",  bus0.cs_n, 1);
    chk("abort_rd_n",  bus0.rd_n, 1);
    chk("abort_ad_oe", bus0.ad_oe, 0);
    chk("abort_we",    mem_we0, 0);
    chk("abort_busy",  busy0, 0);
    reset = 1'b0;
    repeat (20) begin
      step();
      chk("post_we",   mem_we0, 0);
      chk("post_busy", busy0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
